pc_redirect_unit: RTL and testbench



---
 rtl/pc_redirect_unit_pkg.sv | 6 +
 rtl/pc_redirect_unit_pc_next_mux.sv | 32 +++
 rtl/pc_redirect_unit.sv | 86 ++++++++
 tb/tb_pc_redirect_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared PC word type, reset vector and next-PC source encoding
package pc_redirect_unit_pkg;
    typedef logic [31:0] word_t;
    localparam word_t PC_RESET_VEC = 32'hBFC0_0000;
    typedef enum logic [2:0] {PC_SEQ, PC_EXC, PC_BRANCH, PC_JR, PC_JUMP, PC_PENDING} pc_src_t;
endpackage

// File: rtl/pc_redirect_unit_pc_next_mux.sv
// pc_next_mux: combinational priority select of the next fetch PC and its source
module pc_next_mux
    import pc_redirect_unit_pkg::*;
(
    input  logic    exception_i,
    input  word_t   pcexception_i,
    input  logic    branch_taken_i,
    input  word_t   pcbranch_i,
    input  logic    jr_i,
    input  word_t   pcjr_i,
    input  logic    jump_i,
    input  word_t   pcjump_i,
    input  logic    pending_valid_i,
    input  word_t   pending_pc_i,
    input  word_t   pcplus4_i,
    output word_t   next_pc_o,
    output pc_src_t src_o
);
    // exception > branch > jr > jump > buffered redirect > sequential
    always_comb begin
        src_o     = exception_i     ? PC_EXC     :
                    branch_taken_i  ? PC_BRANCH  :
                    jr_i            ? PC_JR      :
                    jump_i          ? PC_JUMP    :
                    pending_valid_i ? PC_PENDING : PC_SEQ;
        next_pc_o = exception_i     ? pcexception_i :
                    branch_taken_i  ? pcbranch_i    :
                    jr_i            ? pcjr_i        :
                    jump_i          ? pcjump_i      :
                    pending_valid_i ? pending_pc_i  : pcplus4_i;
    end
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with stall-safe redirect buffering (optional PC_ALIGN_CHECK_EN)
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter word_t RESET_PC = PC_RESET_VEC,
    parameter int    PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exception,
    input  logic [31:0] pcexception,
    input  logic        branch_taken,
    input  logic [31:0] pcbranchD,
    input  logic        jr,
    input  logic [31:0] pcjrD,
    input  logic        jump,
    input  logic [31:0] pcjumpD,
    output logic [31:0] pcF,
    output logic [31:0] pcplus4F,
    output logic        pending,
    output logic        redirected,
    output logic        pc_misaligned
);
    word_t   pc_q, pending_pc_q, pc_d;
    logic    pending_valid_q, redirected_q;
    pc_src_t src;
    logic    live;

    pc_next_mux u_mux (
        .exception_i     (exception),
        .pcexception_i   (pcexception),
        .branch_taken_i  (branch_taken),
        .pcbranch_i      (pcbranchD),
        .jr_i            (jr),
        .pcjr_i          (pcjrD),
        .jump_i          (jump),
        .pcjump_i        (pcjumpD),
        .pending_valid_i (pending_valid_q),
        .pending_pc_i    (pending_pc_q),
        .pcplus4_i       (pcplus4F),
        .next_pc_o       (pc_d),
        .src_o           (src)
    );

    assign live       = (src == PC_BRANCH) || (src == PC_JR) || (src == PC_JUMP);
    assign pcF        = pc_q;
    assign pcplus4F   = pc_q + word_t'(PC_STEP);
    assign pending    = pending_valid_q;
    assign redirected = redirected_q;

    // exceptions bypass the stall; decode redirects seen while stalled are parked until release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q            <= RESET_PC;
            pending_valid_q <= 1'b0;
            pending_pc_q    <= '0;
            redirected_q    <= 1'b0;
        end else if (exception || !stall) begin
            pc_q            <= pc_d;
            pending_valid_q <= 1'b0;
            redirected_q    <= src != PC_SEQ;
        end else begin
            redirected_q    <= 1'b0;
            if (live) begin
                pending_valid_q <= 1'b1;
                pending_pc_q    <= pc_d;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_q;
    // alignment flag tracks the PC loaded in the same update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misaligned_q <= 1'b0;
        else if (exception || !stall) misaligned_q <= pc_d[1:0] != 2'b00;
    end
    assign pc_misaligned = misaligned_q;
`else
    assign pc_misaligned = 1'b0;
`endif

    // decode redirect sources are mutually exclusive by protocol
    assert property (@(posedge clk) disable iff (!reset) $onehot0({branch_taken, jr, jump}));
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;
    logic        clk, reset, stall, exception, branch_taken, jr, jump;
    logic [31:0] pcexception, pcbranchD, pcjrD, pcjumpD;
    logic [31:0] pcF, pcplus4F;
    logic        pending, redirected, pc_misaligned;
    int total = 0;
    int bad = 0;
`ifdef PC_ALIGN_CHECK_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    pc_redirect_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .exception    (exception),
        .pcexception  (pcexception),
        .branch_taken (branch_taken),
        .pcbranchD    (pcbranchD),
        .jr           (jr),
        .pcjrD        (pcjrD),
        .jump         (jump),
        .pcjumpD      (pcjumpD),
        .pcF          (pcF),
        .pcplus4F     (pcplus4F),
        .pending      (pending),
        .redirected   (redirected),
        .pc_misaligned(pc_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 0; stall = 0; exception = 0; branch_taken = 0; jr = 0; jump = 0;
        pcexception = 0; pcbranchD = 0; pcjrD = 0; pcjumpD = 0;
        step(); step();
        chk("rst_pc", pcF, 32'hBFC0_0000);
        chk("rst_pc4", pcplus4F, 32'hBFC0_0004);
        chk("rst_pend", {31'd0, pending}, 0);
        chk("rst_redir", {31'd0, redirected}, 0);
        chk("rst_mis", {31'd0, pc_misaligned}, 0);
        reset = 1;
        step(); chk("seq1", pcF, 32'hBFC0_0004);
        step(); chk("seq2", pcF, 32'hBFC0_0008);
        step(); chk("seq3", pcF, 32'hBFC0_000C);
        chk("seq_redir", {31'd0, redirected}, 0);
        branch_taken = 1; pcbranchD = 32'h8000_1000;
        step(); branch_taken = 0;
        chk("br_pc", pcF, 32'h8000_1000);
        chk("br_redir", {31'd0, redirected}, 1);
        step();
        chk("br_seq", pcF, 32'h8000_1004);
        chk("br_seq_redir", {31'd0, redirected}, 0);
        stall = 1; jump = 1; pcjumpD = 32'h8000_2000;
        step();
        chk("stj1_pc", pcF, 32'h8000_1004);
        chk("stj1_pend", {31'd0, pending}, 1);
        step();
        chk("stj2_pc", pcF, 32'h8000_1004);
        chk("stj2_pend", {31'd0, pending}, 1);
        chk("stj2_redir", {31'd0, redirected}, 0);
        jump = 0; stall = 0;
        step();
        chk("stj_rel_pc", pcF, 32'h8000_2000);
        chk("stj_rel_pend", {31'd0, pending}, 0);
        chk("stj_rel_redir", {31'd0, redirected}, 1);
        stall = 1; jr = 1; pcjrD = 32'h8000_6000;
        step(); jr = 0; branch_taken = 1; pcbranchD = 32'h8000_7000;
        step(); branch_taken = 0;
        step();
        chk("ovw_hold_pc", pcF, 32'h8000_2000);
        chk("ovw_pend", {31'd0, pending}, 1);
        stall = 0;
        step();
        chk("ovw_pc", pcF, 32'h8000_7000);
        stall = 1; jump = 1; pcjumpD = 32'h8000_2000;
        step(); jump = 0;
        chk("exc_pre_pend", {31'd0, pending}, 1);
        exception = 1; pcexception = 32'hBFC0_0380;
        step(); exception = 0;
        chk("exc_pc", pcF, 32'hBFC0_0380);
        chk("exc_pend", {31'd0, pending}, 0);
        chk("exc_redir", {31'd0, redirected}, 1);
        stall = 0;
        step();
        chk("exc_after", pcF, 32'hBFC0_0384);
        exception = 1; branch_taken = 1; pcbranchD = 32'h8000_9000;
        step(); exception = 0; branch_taken = 0;
        chk("exc_over_br", pcF, 32'hBFC0_0380);
        stall = 1; jump = 1; pcjumpD = 32'h8000_2000;
        step(); stall = 0; jump = 0; branch_taken = 1; pcbranchD = 32'h8000_A000;
        step(); branch_taken = 0;
        chk("live_over_pend", pcF, 32'h8000_A000);
        chk("live_over_pend_p", {31'd0, pending}, 0);
        jr = 1; pcjrD = 32'hFFFF_FFFC;
        step(); jr = 0;
        chk("wrap_pc", pcF, 32'hFFFF_FFFC);
        chk("wrap_pc4", pcplus4F, 32'h0000_0000);
        step();
        chk("wrap_next", pcF, 32'h0000_0000);
        chk("wrap_redir", {31'd0, redirected}, 0);
        jr = 1; pcjrD = 32'h8000_5002;
        step(); jr = 0;
        chk("mis_pc", pcF, 32'h8000_5002);
        chk("mis_flag", {31'd0, pc_misaligned}, {31'd0, MIS});
        step();
        chk("mis_seq", pcF, 32'h8000_5006);
        chk("mis_seq_flag", {31'd0, pc_misaligned}, {31'd0, MIS});
        jump = 1; pcjumpD = 32'h8000_5000;
        step(); jump = 0;
        chk("al_pc", pcF, 32'h8000_5000);
        chk("al_flag", {31'd0, pc_misaligned}, 0);
        stall = 1; jump = 1; pcjumpD = 32'h8000_8000;
        step();
        chk("rst_mid_pend", {31'd0, pending}, 1);
        reset = 0;
        #1;
        chk("arst_pc", pcF, 32'hBFC0_0000);
        chk("arst_pend", {31'd0, pending}, 0);
        jump = 0; stall = 0;
        #1 reset = 1;
        step();
        chk("arst_after", pcF, 32'hBFC0_0004);
        chk("arst_after_p", {31'd0, pending}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
